// File: rtl/prf_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : prf_wb_arbiter
// Brief    : Integer writeback arbiter, NUM_REQ requesters onto two PRF write
//            ports, rotating priority, registered outputs. The starvation
//            guard is built only when PRF_WB_STARVE_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
module prf_wb_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int STARVE_LIMIT   = 8,
  parameter int PREG_IDX_WIDTH = 7,
  parameter int DATA_WIDTH     = 32
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_REQ-1:0]                req_valid,
  input  logic [NUM_REQ*PREG_IDX_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]     req_data,
  output logic [NUM_REQ-1:0]                req_ready,
  output logic                              wb0_we,
  output logic [PREG_IDX_WIDTH-1:0]         wb0_addr,
  output logic [DATA_WIDTH-1:0]             wb0_data,
  output logic                              wb1_we,
  output logic [PREG_IDX_WIDTH-1:0]         wb1_addr,
  output logic [DATA_WIDTH-1:0]             wb1_data,
  output logic [NUM_REQ-1:0]                starved
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int SUM_W = IDX_W + 1;

  logic [PREG_IDX_WIDTH-1:0] addr_arr [NUM_REQ];
  logic [DATA_WIDTH-1:0]     data_arr [NUM_REQ];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign addr_arr[gi] = req_addr[gi*PREG_IDX_WIDTH +: PREG_IDX_WIDTH];
      assign data_arr[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  logic [NUM_REQ-1:0] promoted;
  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   a_idx, b_idx;
  logic               found_a, found_b, a_rot, b_rot, b_ok;

  logic                      wb0_we_q, wb0_we_d, wb1_we_q, wb1_we_d;
  logic [PREG_IDX_WIDTH-1:0] wb0_addr_q, wb0_addr_d, wb1_addr_q, wb1_addr_d;
  logic [DATA_WIDTH-1:0]     wb0_data_q, wb0_data_d, wb1_data_q, wb1_data_d;

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] v);
    if ({1'b0, v} == SUM_W'(NUM_REQ - 1)) return '0;
    return v + IDX_W'(1);
  endfunction

  // Promoted requesters are scanned first in index order, then the rest in
  // rotating order; the first two valid hits become grants A and B.
  always_comb begin
    logic [SUM_W-1:0] pos;
    logic [IDX_W-1:0] cand;
    found_a = 1'b0;
    found_b = 1'b0;
    a_rot   = 1'b0;
    b_rot   = 1'b0;
    a_idx   = '0;
    b_idx   = '0;
    pos     = '0;
    cand    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (req_valid[k] && promoted[k]) begin
        if (!found_a) begin
          found_a = 1'b1;
          a_idx   = IDX_W'(k);
        end else if (!found_b) begin
          found_b = 1'b1;
          b_idx   = IDX_W'(k);
        end
      end
    end
    for (int j = 0; j < NUM_REQ; j++) begin
      pos = {1'b0, rr_ptr_q} + SUM_W'(j);
      if (pos >= SUM_W'(NUM_REQ)) pos = pos - SUM_W'(NUM_REQ);
      cand = pos[IDX_W-1:0];
      if (req_valid[cand] && !promoted[cand]) begin
        if (!found_a) begin
          found_a = 1'b1;
          a_idx   = cand;
          a_rot   = 1'b1;
        end else if (!found_b) begin
          found_b = 1'b1;
          b_idx   = cand;
          b_rot   = 1'b1;
        end
      end
    end
  end

  // A same-preg second grant is simply dropped for this cycle, not replaced.
  always_comb begin
    b_ok  = found_b && (addr_arr[b_idx] != addr_arr[a_idx]);
    grant = '0;
    if (found_a) grant[a_idx] = 1'b1;
    if (b_ok)    grant[b_idx] = 1'b1;
  end

  assign req_ready = rst_n ? grant : '0;

  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    if (b_ok && b_rot)
      rr_ptr_d = wrap_inc(b_idx);
    else if (found_a && a_rot)
      rr_ptr_d = wrap_inc(a_idx);
    wb0_we_d   = found_a;
    wb0_addr_d = found_a ? addr_arr[a_idx] : wb0_addr_q;
    wb0_data_d = found_a ? data_arr[a_idx] : wb0_data_q;
    wb1_we_d   = b_ok;
    wb1_addr_d = b_ok ? addr_arr[b_idx] : wb1_addr_q;
    wb1_data_d = b_ok ? data_arr[b_idx] : wb1_data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q   <= '0;
      wb0_we_q   <= 1'b0;
      wb0_addr_q <= '0;
      wb0_data_q <= '0;
      wb1_we_q   <= 1'b0;
      wb1_addr_q <= '0;
      wb1_data_q <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      wb0_we_q   <= wb0_we_d;
      wb0_addr_q <= wb0_addr_d;
      wb0_data_q <= wb0_data_d;
      wb1_we_q   <= wb1_we_d;
      wb1_addr_q <= wb1_addr_d;
      wb1_data_q <= wb1_data_d;
    end
  end

  assign wb0_we   = wb0_we_q;
  assign wb0_addr = wb0_addr_q;
  assign wb0_data = wb0_data_q;
  assign wb1_we   = wb1_we_q;
  assign wb1_addr = wb1_addr_q;
  assign wb1_data = wb1_data_q;

`ifdef PRF_WB_STARVE_EN
  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  logic [NUM_REQ-1:0] starved_q, starved_d;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_starve
      logic [7:0] cnt_q, cnt_d;

      always_comb begin
        cnt_d = 8'd0;
        if (req_valid[gi] && !grant[gi])
          cnt_d = (cnt_q == LIMIT) ? cnt_q : cnt_q + 8'd1;
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= 8'd0;
        else        cnt_q <= cnt_d;
      end

      assign promoted[gi]  = (cnt_q == LIMIT);
      assign starved_d[gi] = (cnt_d == LIMIT);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) starved_q <= '0;
    else        starved_q <= starved_d;
  end

  assign starved = starved_q;
`else
  logic [31:0] unused_starve_limit;
  assign unused_starve_limit = STARVE_LIMIT;
  assign promoted = '0;
  assign starved  = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_prf_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_prf_wb_arbiter
// Brief    : Random requester traffic against a reference model of the
//            writeback arbiter; a monitor scores the registered write ports.
// Revision : 1.0  initial release
// ============================================================================
module tb_prf_wb_arbiter;

  localparam int N   = 4;
  localparam int AW  = 7;
  localparam int DW  = 32;
  localparam int LIM = 3;
`ifdef PRF_WB_STARVE_EN
  localparam bit STARVE_ON = 1'b1;
`else
  localparam bit STARVE_ON = 1'b0;
`endif

  logic          clk   = 1'b0;
  logic          rst_n = 1'b1;
  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            wb0_we, wb1_we;
  logic [AW-1:0]   wb0_addr, wb1_addr;
  logic [DW-1:0]   wb0_data, wb1_data;
  logic [N-1:0]    starved;

  prf_wb_arbiter #(
    .NUM_REQ(N), .STARVE_LIMIT(LIM), .PREG_IDX_WIDTH(AW), .DATA_WIDTH(DW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready),
    .wb0_we(wb0_we), .wb0_addr(wb0_addr), .wb0_data(wb0_data),
    .wb1_we(wb1_we), .wb1_addr(wb1_addr), .wb1_data(wb1_data),
    .starved(starved)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            tag;
    logic          we0;
    logic [AW-1:0] a0;
    logic [DW-1:0] d0;
    logic          we1;
    logic [AW-1:0] a1;
    logic [DW-1:0] d1;
    logic [N-1:0]  st;
  } rec_t;

  rec_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Requester-side state: what each execution unit is presenting.
  logic [N-1:0]  pv;
  logic [AW-1:0] pa [N];
  logic [DW-1:0] pd [N];
  logic [N-1:0]  prev_rdy;

  // Reference model state.
  int            m_rr;
  int            m_cnt [N];
  logic [AW-1:0] m_a0, m_a1;
  logic [DW-1:0] m_d0, m_d1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_rr = 0;
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
    m_a0 = '0; m_a1 = '0; m_d0 = '0; m_d1 = '0;
  endtask

  // Priority list = starving requesters by index, then rotation from m_rr.
  task automatic model_step(output logic [N-1:0] rdy, output rec_t r);
    int order[$];
    bit prom [N];
    int a, b;
    a = -1;
    b = -1;
    for (int i = 0; i < N; i++) prom[i] = STARVE_ON && (m_cnt[i] == LIM);
    for (int i = 0; i < N; i++) if (prom[i]) order.push_back(i);
    for (int j = 0; j < N; j++) if (!prom[(m_rr + j) % N]) order.push_back((m_rr + j) % N);
    foreach (order[k]) begin
      if (pv[order[k]]) begin
        if (a < 0) a = order[k];
        else if (b < 0) b = order[k];
      end
    end
    if (b >= 0 && pa[b] == pa[a]) b = -1;
    rdy = '0;
    if (a >= 0) rdy[a] = 1'b1;
    if (b >= 0) rdy[b] = 1'b1;
    if (b >= 0 && !prom[b])      m_rr = (b + 1) % N;
    else if (a >= 0 && !prom[a]) m_rr = (a + 1) % N;
    r.st = '0;
    for (int i = 0; i < N; i++) begin
      if (STARVE_ON && pv[i] && !rdy[i]) m_cnt[i] = (m_cnt[i] < LIM) ? m_cnt[i] + 1 : LIM;
      else m_cnt[i] = 0;
      r.st[i] = STARVE_ON && (m_cnt[i] == LIM);
    end
    if (a >= 0) begin m_a0 = pa[a]; m_d0 = pd[a]; end
    if (b >= 0) begin m_a1 = pa[b]; m_d1 = pd[b]; end
    r.tag = 0;
    r.we0 = (a >= 0); r.a0 = m_a0; r.d0 = m_d0;
    r.we1 = (b >= 0); r.a1 = m_a1; r.d1 = m_d1;
  endtask

  // mode 0: per-requester disjoint pregs; 1: tiny range (conflicts); 2: any.
  function automatic logic [AW-1:0] new_addr(input int i, input int mode);
    logic [AW-1:0] a;
    a = AW'($urandom);
    if (mode == 0)      a[AW-1:AW-2] = 2'(i);
    else if (mode == 1) a = AW'($urandom_range(0, 5));
    return a;
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i]             = pv[i];
      req_addr[i*AW +: AW]     = pa[i];
      req_data[i*DW +: DW]     = pd[i];
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_wb0_we"},   wb0_we,   '0);
    chk({tag, "_wb1_we"},   wb1_we,   '0);
    chk({tag, "_wb0_addr"}, wb0_addr, '0);
    chk({tag, "_wb1_addr"}, wb1_addr, '0);
    chk({tag, "_wb0_data"}, wb0_data, '0);
    chk({tag, "_wb1_data"}, wb1_data, '0);
    chk({tag, "_starved"},  starved,  '0);
    chk({tag, "_ready"},    req_ready, '0);
  endtask

  // kind: 0 normal, 1 only req2 with a fixed payload, 2 also check that payload landed.
  task automatic run_cycle(input int pct, input int mode, input int kind);
    logic [N-1:0] rdy;
    rec_t r;
    @(posedge clk);
    #1;
    if (!rst_n) rst_n = 1'b1;
    if (kind == 2) begin
      chk("single_wb0_we",   wb0_we,   1'b1);
      chk("single_wb0_addr", wb0_addr, 7'd45);
      chk("single_wb0_data", wb0_data, 32'hDEADBEEF);
      chk("single_wb1_we",   wb1_we,   1'b0);
    end
    for (int i = 0; i < N; i++) if (prev_rdy[i]) pv[i] = 1'b0;
    if (kind == 1) begin
      pv    = 4'b0100;
      pa[2] = 7'd45;
      pd[2] = 32'hDEADBEEF;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (!pv[i] && $urandom_range(0, 99) < pct) begin
          pv[i] = 1'b1;
          pa[i] = new_addr(i, mode);
          pd[i] = $urandom;
        end
      end
    end
    drive();
    model_step(rdy, r);
    r.tag = cyc;
    sb.push_back(r);
    #3;
    chk("req_ready", req_ready, rdy);
    if (kind == 1) chk("single_ready", req_ready, 4'b0100);
    prev_rdy = rdy;
  endtask

  task automatic mid_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    sb.delete();
    model_reset();
    prev_rdy = '0;
    for (int i = 0; i < N; i++) begin
      pv[i] = 1'b1;
      pa[i] = new_addr(i, 0);
      pd[i] = $urandom;
    end
    drive();
    #1;
    chk("midrst_ready_held", req_ready, '0);
    repeat (2) @(posedge clk);
  endtask

  // Scoreboard monitor: the record for input cycle c is due after edge c+1.
  initial begin
    rec_t r;
    forever begin
      @(posedge clk);
      #2;
      if (rst_n) begin
        while (sb.size() > 0 && sb[0].tag < cyc - 1) begin
          r = sb.pop_front();
          chk("sb_stale_tag", r.tag, cyc - 1);
        end
        if (sb.size() > 0 && sb[0].tag == cyc - 1) begin
          r = sb.pop_front();
          chk("wb0_we",   wb0_we,   r.we0);
          chk("wb0_addr", wb0_addr, r.a0);
          chk("wb0_data", wb0_data, r.d0);
          chk("wb1_we",   wb1_we,   r.we1);
          chk("wb1_addr", wb1_addr, r.a1);
          chk("wb1_data", wb1_data, r.d1);
          chk("starved",  starved,  r.st);
        end else begin
          chk("idle_we", {wb0_we, wb1_we}, 2'b00);
        end
      end
    end
  end

  initial begin
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
    pv        = '0;
    prev_rdy  = '0;
    for (int i = 0; i < N; i++) begin pa[i] = '0; pd[i] = '0; end
    model_reset();

    #1 rst_n = 1'b0;
    #2;
    chk_reset_outputs("rst");

    repeat (30)  run_cycle(100, 0, 0);
    repeat (300) run_cycle(50, 1, 0);

    mid_reset();
    run_cycle(100, 0, 0);
    chk("post_reset_ready", req_ready, 4'b0011);

    repeat (300) run_cycle(30, 2, 0);
    repeat (6)   run_cycle(0, 2, 0);
    run_cycle(0, 0, 1);
    run_cycle(0, 0, 2);
    repeat (300) run_cycle(80, 1, 0);

    @(posedge clk);
    #1;
    req_valid = '0;
    repeat (3) @(posedge clk);
    #3;
    chk("sb_drain", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
